// File: rtl/vga_pixel_buffer.sv
// ============================================================================
// Module   : vga_pixel_buffer
// Purpose  : Frame-aligned elastic RGB565 FIFO feeding the VGA driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_pixel_buffer #(
   parameter int              DATA_W     = 16,
   parameter int              DEPTH      = 1024,
   parameter int              AW         = 10,
   parameter int              PRIME_LVL  = 512,
   parameter logic [DATA_W-1:0] FILL_COLOR = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_vld,
   input  logic              din_sop,
   output logic              din_rdy,
   input  logic              frm_req,
   input  logic              pix_req,
   output logic [DATA_W-1:0] dout,
   output logic              dout_vld,
   output logic              underflow,
   input  logic              clr_err,
   output logic [AW:0]       fill_lvl
);

   localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);
   localparam logic [AW:0] c_prime = (AW+1)'(PRIME_LVL);

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_fill;
   logic [DATA_W-1:0] r_dout;
   logic              r_dout_vld;
   logic              r_underflow;

   logic              w_rdy;
   logic              w_push;
   logic              w_wr;
   logic              w_pop;
   logic              w_uf;

   // While hunting every beat is accepted, but only a start-of-frame is kept.
   always_comb begin
      w_rdy  = 1'b1;
      if (r_state != HUNT) begin
         w_rdy = (r_fill != c_depth);
      end
      w_push = din_vld & w_rdy;
      w_wr   = w_push & ((r_state != HUNT) | din_sop);
      w_pop  = pix_req & (r_state == RUN) & (r_fill != '0);
      w_uf   = pix_req & (r_state == RUN) & (r_fill == '0);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         HUNT: begin
            if (w_wr) begin
               w_state_nxt = FILL;
            end
         end
         FILL: begin
            if (frm_req && (r_fill >= c_prime)) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_uf) begin
               w_state_nxt = HUNT;
            end
         end
         default: w_state_nxt = HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= HUNT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // An underflow flushes the whole buffer so realignment starts from empty.
   always_ff @(posedge clk) begin
      if (rst || w_uf) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr, w_pop})
            2'b10:   r_fill <= r_fill + 1'b1;
            2'b01:   r_fill <= r_fill - 1'b1;
            default: r_fill <= r_fill;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dout     <= '0;
         r_dout_vld <= 1'b0;
      end else begin
         r_dout_vld <= pix_req;
         if (w_pop) begin
            r_dout <= r_mem[r_rd_ptr];
         end else if (pix_req) begin
            r_dout <= FILL_COLOR;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_underflow <= 1'b0;
      end else if (w_uf) begin
         r_underflow <= 1'b1;
      end else if (clr_err) begin
         r_underflow <= 1'b0;
      end
   end

   assign din_rdy   = w_rdy;
   assign dout      = r_dout;
   assign dout_vld  = r_dout_vld;
   assign underflow = r_underflow;
   assign fill_lvl  = r_fill;

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_buffer.sv
// ============================================================================
// Module   : tb_vga_pixel_buffer
// Purpose  : Randomized scoreboard bench for vga_pixel_buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_pixel_buffer;

   localparam int          DEPTH = 1024;
   localparam int          PRIME = 512;
   localparam logic [15:0] FILLC = 16'h0000;
   localparam int          M_HUNT = 0;
   localparam int          M_FILL = 1;
   localparam int          M_RUN  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] din;
   logic        din_vld, din_sop, din_rdy, frm_req, pix_req;
   logic [15:0] dout;
   logic        dout_vld, underflow, clr_err;
   logic [10:0] fill_lvl;

   vga_pixel_buffer dut (
      .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_sop(din_sop),
      .din_rdy(din_rdy), .frm_req(frm_req), .pix_req(pix_req), .dout(dout),
      .dout_vld(dout_vld), .underflow(underflow), .clr_err(clr_err), .fill_lvl(fill_lvl)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] m_q[$];
   logic [15:0] exp_q[$];
   int          m_st;
   logic        m_uf;
   logic        m_last_pix;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Scoreboard monitor: every presented pixel is matched against the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (dout_vld === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("dout_unexpected", 32'(dout_vld), 32'd0);
         end else begin
            chk("dout", 32'(dout), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; din_vld = 0; din_sop = 0; frm_req = 0; pix_req = 0; clr_err = 0; din = '0;
      @(negedge clk);
      rst = 1'b0;
      m_q.delete(); exp_q.delete();
      m_st = M_HUNT; m_uf = 1'b0; m_last_pix = 1'b0;
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_dout_vld", 32'(dout_vld), 32'd0);
      chk("rst_fill", 32'(fill_lvl), 32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
   endtask

   // One clock of stimulus; the model applies the buffer's rules to the same inputs.
   task automatic step(input logic vld, input logic sop, input logic [15:0] d,
                       input logic frm, input logic pix, input logic clr);
      logic rdy, pop, uf, wr;
      int   sz;
      @(negedge clk);
      chk("fill_lvl", 32'(fill_lvl), 32'(m_q.size()));
      chk("underflow", 32'(underflow), 32'(m_uf));
      chk("dout_vld", 32'(dout_vld), 32'(m_last_pix));
      sz  = m_q.size();
      rdy = (m_st == M_HUNT) ? 1'b1 : (sz != DEPTH);
      chk("din_rdy", 32'(din_rdy), 32'(rdy));
      din = d; din_vld = vld; din_sop = sop; frm_req = frm; pix_req = pix; clr_err = clr;
      pop = pix && (m_st == M_RUN) && (sz != 0);
      uf  = pix && (m_st == M_RUN) && (sz == 0);
      wr  = vld && rdy && ((m_st != M_HUNT) || sop);
      if (pix) exp_q.push_back(pop ? m_q[0] : FILLC);
      m_last_pix = pix;
      if (uf) begin
         m_q.delete();
         m_st = M_HUNT;
         m_uf = 1'b1;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (wr) m_q.push_back(d);
         if (m_st == M_HUNT && wr) m_st = M_FILL;
         else if (m_st == M_FILL && frm && sz >= PRIME) m_st = M_RUN;
         if (clr) m_uf = 1'b0;
      end
   endtask

   task automatic push_n(input int n, input logic first_sop);
      for (int i = 0; i < n; i++) step(1'b1, first_sop && (i == 0), 16'($urandom), 0, 0, 0);
   endtask

   task automatic pix_n(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0, 1, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; din = '0; din_vld = 0; din_sop = 0; frm_req = 0; pix_req = 0; clr_err = 0;
      do_reset();

      // Frame primed above threshold, played out in order.
      push_n(600, 1'b1);
      step(0, 0, 0, 1, 0, 0);
      pix_n(600);
      step(0, 0, 0, 0, 0, 0);

      // Saturate across a pointer wrap, release one slot, then drain.
      push_n(1100, 1'b0);
      pix_n(1);
      step(0, 0, 0, 0, 0, 0);
      pix_n(1023);

      // Underflow from empty RUN, then clear.
      pix_n(1);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);

      // Randomized mixed traffic.
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), 16'($urandom),
              ($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 49) == 0));
      end
      step(0, 0, 0, 0, 0, 0);

      // Non-sop beats are dropped while hunting; sop starts the fill.
      do_reset();
      push_n(20, 1'b0);
      step(1, 1, 16'hF800, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Under-primed frame request keeps showing fill colour.
      push_n(99, 1'b0);
      step(0, 0, 0, 1, 0, 0);
      pix_n(10);
      step(0, 0, 0, 0, 0, 0);

      // Reset mid-run with data buffered.
      do_reset();
      push_n(600, 1'b1);
      step(0, 0, 0, 1, 0, 0);
      pix_n(300);
      step(0, 0, 0, 0, 0, 0);
      do_reset();
      step(0, 0, 0, 0, 0, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
